// File: rtl/cell_arc_pkg.sv
// Shared types and helpers for the standard-cell arc sequencer.
// No logic of its own; holds the state encoding, the Gray mapping and the OA221 truth table.
// No flow control.
package cell_arc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Q = (IN1|IN2)&(IN3|IN4)&IN5, indexed by the applied input vector
    localparam logic [31:0] TRUTH_OA221 = 32'hEEE0_0000;

    // Binary-reflected Gray code: neighbouring indices differ in one bit
    function automatic logic [31:0] gray(input logic [31:0] i);
        return i ^ (i >> 1);
    endfunction

endpackage

// File: rtl/cell_arc_gray.sv
// Maps a binary sweep index to the Gray-coded cell input vector.
// Purely combinational, zero cycles.
// No flow control.
module cell_arc_gray
    import cell_arc_pkg::*;
#(
    parameter int NIN = 5
) (
    input  logic [NIN-1:0] bin_i,
    output logic [NIN-1:0] gray_o
);

    assign gray_o = NIN'(gray(32'(bin_i)));

endmodule

// File: rtl/cell_arc_sequencer.sv
// Walks a 5-input cell through a Gray-code sweep, checks Q against a truth table, counts toggles/errors.
// Each vector is held SETTLE+1 cycles; sample and next vector share an edge; DONE follows the last sample.
// No backpressure: START is taken only in IDLE, ABORT cancels a running sweep on the next edge.
module cell_arc_sequencer
    import cell_arc_pkg::*;
#(
    parameter int                   NIN    = 5,
    parameter int unsigned          SETTLE = 2,
    parameter logic [(1<<NIN)-1:0]  TRUTH  = TRUTH_OA221
) (
    input  logic           clk_i,
    input  logic           rstb_i,
    input  logic           start_i,
    input  logic           abort_i,
    input  logic           resp_i,
    output logic [NIN-1:0] stim_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           pass_o,
    output logic [NIN:0]   toggles_o,
    output logic [NIN:0]   errors_o,
    output logic [NIN-1:0] fail_vec_o
);

    localparam int          CW       = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [NIN:0] LAST_IDX = (NIN+1)'(1 << NIN);

    state_t         state_q;
    logic [NIN:0]   idx_q;
    logic [CW-1:0]  cnt_q;
    logic           prev_q;
    logic [NIN-1:0] stim_q;
    logic           busy_q;
    logic           done_q;
    logic           pass_q;
    logic [NIN:0]   toggles_q;
    logic [NIN:0]   errors_q;
    logic [NIN-1:0] fail_vec_q;

    logic [NIN-1:0] stim_d;
    logic           mismatch;
    logic           last_sample;

    // Vector for the next index; the index wraps so the final vector is g(0) again
    cell_arc_gray #(.NIN(NIN)) u_gray (
        .bin_i  (idx_q[NIN-1:0] + NIN'(1)),
        .gray_o (stim_d)
    );

    assign mismatch    = (resp_i != TRUTH[stim_q]);
    assign last_sample = (idx_q == LAST_IDX);

    // Sweep FSM with its settle counter, index and result counters
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            prev_q     <= 1'b0;
            stim_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            toggles_q  <= '0;
            errors_q   <= '0;
            fail_vec_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (abort_i) begin
                        // abort outranks a simultaneous start
                        pass_q <= 1'b0;
                        stim_q <= '0;
                    end else if (start_i) begin
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        toggles_q  <= '0;
                        errors_q   <= '0;
                        fail_vec_q <= '0;
                        idx_q      <= '0;
                        stim_q     <= '0;
                        cnt_q      <= CW'(SETTLE);
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        // partial counts are left visible for debug
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        stim_q  <= '0;
                        pass_q  <= 1'b0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        if ((idx_q != '0) && (resp_i != prev_q)) begin
                            toggles_q <= toggles_q + (NIN+1)'(1);
                        end
                        if (mismatch) begin
                            errors_q <= errors_q + (NIN+1)'(1);
                            if (errors_q == '0) begin
                                fail_vec_q <= stim_q;
                            end
                        end
                        prev_q <= resp_i;
                        idx_q  <= idx_q + (NIN+1)'(1);
                        cnt_q  <= CW'(SETTLE);
                        if (last_sample) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            stim_q  <= '0;
                            pass_q  <= (errors_q == '0) && !mismatch;
                        end else begin
                            stim_q <= stim_d;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign stim_o     = stim_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign toggles_o  = toggles_q;
    assign errors_o   = errors_q;
    assign fail_vec_o = fail_vec_q;

endmodule

// File: tb/tb_cell_arc_sequencer.sv
// Directed bench for cell_arc_sequencer with default parameters (NIN=5, SETTLE=2, OA221).
// Sweeps with an OA221 model and with Q tied low/high, plus abort and mid-sweep reset cases.
// Outputs are sampled 1 time unit after the rising edge.
module tb_cell_arc_sequencer;

    logic       clk_i = 1'b0;
    logic       rstb_i;
    logic       start_i;
    logic       abort_i;
    logic       resp_i;
    logic [4:0] stim_o;
    logic       busy_o;
    logic       done_o;
    logic       pass_o;
    logic [5:0] toggles_o;
    logic [5:0] errors_o;
    logic [4:0] fail_vec_o;

    int mode = 0;      // 0: OA221 model, 1: Q tied 0, 2: Q tied 1
    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    assign resp_i = (mode == 0) ? ((stim_o[0] | stim_o[1]) & (stim_o[2] | stim_o[3]) & stim_o[4])
                  : (mode == 1) ? 1'b0 : 1'b1;

    cell_arc_sequencer #(
        .NIN    (5),
        .SETTLE (2),
        .TRUTH  (32'hEEE0_0000)
    ) dut (
        .clk_i      (clk_i),
        .rstb_i     (rstb_i),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .resp_i     (resp_i),
        .stim_o     (stim_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .pass_o     (pass_o),
        .toggles_o  (toggles_o),
        .errors_o   (errors_o),
        .fail_vec_o (fail_vec_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_stim"},    32'(stim_o),     32'h0);
        chk({tag, "_busy"},    32'(busy_o),     32'h0);
        chk({tag, "_done"},    32'(done_o),     32'h0);
        chk({tag, "_pass"},    32'(pass_o),     32'h0);
        chk({tag, "_toggles"}, 32'(toggles_o),  32'h0);
        chk({tag, "_errors"},  32'(errors_o),   32'h0);
        chk({tag, "_failvec"}, 32'(fail_vec_o), 32'h0);
    endtask

    // Full sweep from IDLE: start on edge 0, optional START pulse on edge `poke`
    task automatic run_sweep(input string tag, input int m, input int poke,
                             input int exp_pass, input int exp_err, input int exp_tog,
                             input int exp_fv);
        int         done_edge;
        int         walk_bad;
        int         changes;
        int         n;
        logic [4:0] prev;
        mode    = m;
        start_i = 1'b1;
        tick();                              // edge 0
        start_i = 1'b0;
        chk({tag, "_busy_e0"}, 32'(busy_o), 32'h1);
        chk({tag, "_stim_e0"}, 32'(stim_o), 32'h0);
        done_edge = -1;
        walk_bad  = 0;
        changes   = 0;
        prev      = stim_o;
        n         = 1;
        while (n <= 300 && done_edge < 0) begin
            if (n == poke) start_i = 1'b1;
            tick();
            start_i = 1'b0;
            if (done_o) begin
                done_edge = n;
                if (stim_o != 5'd0) walk_bad++;
            end else begin
                if (!busy_o) walk_bad++;
                if (n % 3 == 0) begin
                    changes++;
                    if ($countones(stim_o ^ prev) != 1) walk_bad++;
                end else if (stim_o != prev) begin
                    walk_bad++;
                end
            end
            prev = stim_o;
            n++;
        end
        chk({tag, "_done_edge"}, 32'(done_edge), 32'd99);
        chk({tag, "_walk_bad"},  32'(walk_bad),  32'd0);
        chk({tag, "_changes"},   32'(changes),   32'd32);
        chk({tag, "_busy_done"}, 32'(busy_o),    32'h0);
        chk({tag, "_pass"},      32'(pass_o),    32'(exp_pass));
        chk({tag, "_errors"},    32'(errors_o),  32'(exp_err));
        chk({tag, "_toggles"},   32'(toggles_o), 32'(exp_tog));
        chk({tag, "_failvec"},   32'(fail_vec_o), 32'(exp_fv));
        tick();
        chk({tag, "_done_drop"}, 32'(done_o), 32'h0);
        chk({tag, "_pass_hold"}, 32'(pass_o), 32'(exp_pass));
    endtask

    initial begin
        int seen_done;
        rstb_i  = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        #12;
        chk_reset_vals("reset");
        rstb_i = 1'b1;
        tick();
        tick();

        // OA221 model, with an ignored START pulse mid-sweep
        run_sweep("oa221", 0, 40, 1, 0, 4, 5'h00);
        // Q stuck low: the 9 true entries fail, first at 5'h19
        run_sweep("tie0", 1, 0, 0, 9, 0, 5'h19);
        // Q stuck high: 23 false entries plus the closing g(0)
        run_sweep("tie1", 2, 0, 0, 24, 0, 5'h00);

        // Abort on edge 40 with Q stuck high: 13 samples taken (edges 3..39)
        mode    = 2;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (39) tick();
        chk("abort_busy_before", 32'(busy_o), 32'h1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_busy",    32'(busy_o),   32'h0);
        chk("abort_stim",    32'(stim_o),   32'h0);
        chk("abort_pass",    32'(pass_o),   32'h0);
        chk("abort_errors",  32'(errors_o), 32'd13);
        seen_done = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (done_o || busy_o) seen_done++;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);

        // ABORT and START together in IDLE: nothing starts, counters untouched
        abort_i = 1'b1;
        start_i = 1'b1;
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        chk("abst_busy",   32'(busy_o),   32'h0);
        chk("abst_stim",   32'(stim_o),   32'h0);
        tick();
        tick();
        chk("abst_busy2",  32'(busy_o),   32'h0);
        chk("abst_errors", 32'(errors_o), 32'd13);

        // Asynchronous reset mid-sweep at cycle 50
        mode    = 2;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (49) tick();
        chk("rst_busy_before",   32'(busy_o),   32'h1);
        chk("rst_errors_before", 32'(errors_o), 32'd16);
        #2;
        rstb_i = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        tick();
        rstb_i = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy_o), 32'h0);
        run_sweep("clean", 0, 0, 1, 0, 4, 5'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
